// File: rtl/ddr_rd_gen2d_pkg.sv
// Shared widths, FSM state encoding and the bit-width helper for the DDR read-request generator.
package ddr_rd_gen2d_pkg;

   localparam int GP_DDR_W      = 512;
   localparam int GP_DDR_ADDR_W = 32;
   localparam int GP_BURST_W    = 8;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   // Bits needed to hold the value itself (not value-1).
   function automatic int bw(input int value);
      if (value < 2) return 1;
      return $clog2(value + 1);
   endfunction

endpackage

// File: rtl/ddr_burst_split.sv
// Walks one row of beats as a sequence of bursts no longer than MAX_BURST,
// reloading the row length automatically after the last chunk.
module ddr_burst_split #(
   parameter int BURST_W   = 8,
   parameter int MAX_BURST = 32
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               advance,
   input  logic [BURST_W-1:0] row_beats,
   output logic [BURST_W-1:0] size,
   output logic [BURST_W-1:0] next_size,
   output logic               last
);

   localparam logic [BURST_W-1:0] MB = BURST_W'(MAX_BURST);

   logic [BURST_W-1:0] rem_reg;
   logic [BURST_W-1:0] rem_next;

   assign last = (rem_reg <= MB);
   assign size = last ? rem_reg : MB;

   always_comb begin
      rem_next = rem_reg;
      if (load) begin
         rem_next = row_beats;
      end else if (advance) begin
         rem_next = last ? row_beats : (rem_reg - MB);
      end
   end

   // Size presented in the following cycle; lets the top evaluate the throttle one cycle ahead.
   assign next_size = (rem_next <= MB) ? rem_next : MB;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_reg <= '0;
      end else begin
         rem_reg <= rem_next;
      end
   end

endmodule

// File: rtl/ddr_rd_gen2d.sv
// Two-level strided DDR read-request generator: planes of rows, rows split into bursts,
// with an outstanding-beat throttle and completion only after all data beats are accepted.
module ddr_rd_gen2d
   import ddr_rd_gen2d_pkg::*;
#(
   parameter int DDR_ADDR_W = GP_DDR_ADDR_W,
   parameter int BURST_W    = GP_BURST_W,
   parameter int CNT_W      = 12,
   parameter int BEAT_BYTES = GP_DDR_W / 8,
   parameter int MAX_BURST  = 32,
   parameter int MAX_OUT    = 128
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   input  logic [DDR_ADDR_W-1:0] conf_st_addr,
   input  logic [BURST_W-1:0]    conf_row_beats,
   input  logic [DDR_ADDR_W-1:0] conf_row_step,
   input  logic [CNT_W-1:0]      conf_row_num,
   input  logic [DDR_ADDR_W-1:0] conf_plane_step,
   input  logic [CNT_W-1:0]      conf_plane_num,
   output logic [DDR_ADDR_W-1:0] ddr_addr,
   output logic [BURST_W-1:0]    ddr_size,
   output logic                  ddr_addr_valid,
   input  logic                  ddr_addr_ready,
   input  logic                  ddr_valid,
   input  logic                  ddr_ready,
   output logic                  err_extra_beat
);

   localparam int OUT_W = bw(MAX_OUT + MAX_BURST);
   localparam logic [DDR_ADDR_W-1:0] CHUNK_BYTES = DDR_ADDR_W'(MAX_BURST * BEAT_BYTES);
   localparam logic [OUT_W:0]        OUT_LIMIT   = (OUT_W+1)'(MAX_OUT);

   state_t state_reg, state_next;

   logic [BURST_W-1:0]    row_beats_reg;
   logic [DDR_ADDR_W-1:0] row_step_reg, plane_step_reg;
   logic [CNT_W-1:0]      row_num_reg, plane_num_reg;
   logic [CNT_W-1:0]      row_cnt_reg, plane_cnt_reg;
   logic [DDR_ADDR_W-1:0] row_base_reg, plane_base_reg, addr_reg;
   logic                  valid_reg;
   logic                  err_reg;
   logic [OUT_W-1:0]      out_reg, out_next;

   logic                  start_acc, zero_desc, addr_hs, beat, extra;
   logic                  last_row, last_plane, final_hs, fits;
   logic [BURST_W-1:0]    chunk_size, next_size;
   logic                  chunk_last;
   logic [DDR_ADDR_W-1:0] row_base_next, plane_base_next;

   ddr_burst_split #(
      .BURST_W   (BURST_W),
      .MAX_BURST (MAX_BURST)
   ) u_split (
      .clk       (clk),
      .rst       (rst),
      .load      (start_acc),
      .advance   (addr_hs),
      .row_beats (start_acc ? conf_row_beats : row_beats_reg),
      .size      (chunk_size),
      .next_size (next_size),
      .last      (chunk_last)
   );

   assign start_acc  = start && (state_reg == ST_IDLE);
   assign zero_desc  = (conf_row_beats == '0) || (conf_row_num == '0) || (conf_plane_num == '0);
   assign addr_hs    = valid_reg && ddr_addr_ready;
   assign beat       = ddr_valid && ddr_ready;
   // A beat nobody asked for is flagged and never allowed to underflow the counter.
   assign extra      = beat && ((state_reg == ST_IDLE) || (out_reg == '0));
   assign last_row   = (row_cnt_reg == row_num_reg - CNT_W'(1));
   assign last_plane = (plane_cnt_reg == plane_num_reg - CNT_W'(1));
   assign final_hs   = addr_hs && chunk_last && last_row && last_plane;

   assign row_base_next   = row_base_reg + row_step_reg;
   assign plane_base_next = plane_base_reg + plane_step_reg;

   assign out_next = out_reg
                   + (addr_hs ? OUT_W'(chunk_size) : '0)
                   - ((beat && !extra) ? OUT_W'(1) : '0);
   assign fits = (({1'b0, out_next} + (OUT_W+1)'(next_size)) <= OUT_LIMIT);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (start_acc) state_next = zero_desc ? ST_DONE : ST_ISSUE;
         ST_ISSUE: if (final_hs) state_next = (out_next == '0) ? ST_DONE : ST_DRAIN;
         ST_DRAIN: if (out_next == '0) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         row_beats_reg  <= '0;
         row_step_reg   <= '0;
         plane_step_reg <= '0;
         row_num_reg    <= '0;
         plane_num_reg  <= '0;
         row_cnt_reg    <= '0;
         plane_cnt_reg  <= '0;
         row_base_reg   <= '0;
         plane_base_reg <= '0;
         addr_reg       <= '0;
         valid_reg      <= 1'b0;
         err_reg        <= 1'b0;
         out_reg        <= '0;
      end else begin
         state_reg <= state_next;
         out_reg   <= start_acc ? '0 : out_next;
         err_reg   <= start_acc ? 1'b0 : (err_reg | extra);
         if (start_acc) begin
            row_beats_reg  <= conf_row_beats;
            row_step_reg   <= conf_row_step;
            plane_step_reg <= conf_plane_step;
            row_num_reg    <= conf_row_num;
            plane_num_reg  <= conf_plane_num;
            row_cnt_reg    <= '0;
            plane_cnt_reg  <= '0;
            row_base_reg   <= conf_st_addr;
            plane_base_reg <= conf_st_addr;
            addr_reg       <= conf_st_addr;
            valid_reg      <= !zero_desc;
         end else if (state_reg == ST_ISSUE) begin
            if (addr_hs) begin
               if (!chunk_last) begin
                  addr_reg <= addr_reg + CHUNK_BYTES;
               end else if (!last_row) begin
                  row_cnt_reg  <= row_cnt_reg + CNT_W'(1);
                  row_base_reg <= row_base_next;
                  addr_reg     <= row_base_next;
               end else if (!last_plane) begin
                  plane_cnt_reg  <= plane_cnt_reg + CNT_W'(1);
                  row_cnt_reg    <= '0;
                  plane_base_reg <= plane_base_next;
                  row_base_reg   <= plane_base_next;
                  addr_reg       <= plane_base_next;
               end
            end
            // A presented request holds until accepted; otherwise the throttle decides.
            if (final_hs) begin
               valid_reg <= 1'b0;
            end else if (addr_hs || !valid_reg) begin
               valid_reg <= fits;
            end
         end
      end
   end

   assign busy           = (state_reg == ST_ISSUE) || (state_reg == ST_DRAIN);
   assign done           = (state_reg == ST_DONE);
   assign ddr_addr       = addr_reg;
   assign ddr_size       = chunk_size;
   assign ddr_addr_valid = valid_reg;
   assign err_extra_beat = err_reg;

endmodule
